// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU bitwise path.
//   logic_op_t : bitwise operation encoding used by logic_block and the issuer
//   state_t    : issuer FSM state encoding (also exported on the debug port)
//   cnt_width  : width of the lane counter for a given lane count (>= 1 bit)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        LOP_NOTB = 2'd0,
        LOP_AND  = 2'd1,
        LOP_OR   = 2'd2,
        LOP_XOR  = 2'd3
    } logic_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-lane issuer still needs a 1-bit counter so the part-select
    // arithmetic stays well formed.
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/logic_block.sv
// ---------------------------------------------------------------------------
// logic_block
//   One word-wide bitwise unit. Purely combinational.
//   op_i   : operation (logic_op_t)
//   a_i    : operand A lane
//   b_i    : operand B lane
//   b_n_i  : inverted operand B lane (precomputed by the caller)
//   r_o    : result lane
// ---------------------------------------------------------------------------
module logic_block
    import alu_pkg::*;
#(
    parameter int word_width = 16
) (
    input  logic_op_t             op_i,
    input  logic [word_width-1:0] a_i,
    input  logic [word_width-1:0] b_i,
    input  logic [word_width-1:0] b_n_i,
    output logic [word_width-1:0] r_o
);

    always_comb begin
        r_o = '0;
        case (op_i)
            LOP_NOTB: r_o = b_n_i;
            LOP_AND:  r_o = a_i & b_i;
            LOP_OR:   r_o = a_i | b_i;
            LOP_XOR:  r_o = a_i ^ b_i;
            default:  r_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_serial_issuer.sv
// ---------------------------------------------------------------------------
// logic_serial_issuer
//   Accepts one wide bitwise request, runs it lane by lane through a single
//   logic_block, assembles the wide result and returns it.
//
//   Handshakes (both sides): a transfer happens at a rising clk_i edge where
//   valid and ready are both 1. A producer holds valid (and its payload)
//   until the transfer; ready never depends on the same side's valid.
//
//   Ports
//     clk_i, rst_i       clock, synchronous active-high reset
//     req_valid_i/ready_o request handshake; req_op_i, req_a_i, req_b_i payload
//     rsp_valid_o/ready_i response handshake; rsp_r_o, rsp_zero_o payload
//     busy_o             1 while a request is in RUN or DONE
//     dbg_state_o        current FSM state, for observation only
// ---------------------------------------------------------------------------
module logic_serial_issuer
    import alu_pkg::*;
#(
    parameter int word_width = 16,
    parameter int lanes      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [word_width*lanes-1:0] req_a_i,
    input  logic [word_width*lanes-1:0] req_b_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [word_width*lanes-1:0] rsp_r_o,
    output logic                        rsp_zero_o,
    output logic                        busy_o,
    output state_t                      dbg_state_o
);

    localparam int                W     = word_width * lanes;
    localparam int                CNT_W = cnt_width(lanes);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(lanes - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
    logic_op_t        op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic             zero_q, zero_d;

    logic                  accept;
    logic [word_width-1:0] lane_a;
    logic [word_width-1:0] lane_b;
    logic [word_width-1:0] lane_b_n;
    logic [word_width-1:0] lane_r;

    // Lane selection for the shared logic_block
    assign lane_a   = a_q[int'(lane_cnt_q) * word_width +: word_width];
    assign lane_b   = b_q[int'(lane_cnt_q) * word_width +: word_width];
    assign lane_b_n = ~lane_b;

    logic_block #(
        .word_width(word_width)
    ) u_logic_block (
        .op_i  (op_q),
        .a_i   (lane_a),
        .b_i   (lane_b),
        .b_n_i (lane_b_n),
        .r_o   (lane_r)
    );

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        zero_d     = zero_q;

        // In DONE a new request may be taken on the same edge the result leaves.
        req_ready_o = (state_q == IDLE) | ((state_q == DONE) & rsp_ready_i);
        accept      = req_valid_i & req_ready_o;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                res_d[int'(lane_cnt_q) * word_width +: word_width] = lane_r;
                if (lane_cnt_q == LAST) begin
                    state_d = DONE;
                    // Includes the lane written this cycle.
                    zero_d  = ~|res_d;
                end else begin
                    lane_cnt_d = lane_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            op_d       = logic_op_t'(req_op_i);
            a_d        = req_a_i;
            b_d        = req_b_i;
            res_d      = '0;
            lane_cnt_d = '0;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            op_q       <= LOP_NOTB;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
        end
    end

    assign rsp_valid_o = (state_q == DONE);
    assign rsp_r_o     = res_q;
    assign rsp_zero_o  = zero_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_logic_serial_issuer.sv
module tb_logic_serial_issuer;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- DUT with 4 lanes ----------------
  logic        rst4 = 1'b1, v4 = 1'b0, rr4 = 1'b1;
  logic [1:0]  op4 = '0;
  logic [63:0] a4 = '0, b4 = '0;
  logic        ready4, rv4, z4, busy4;
  logic [63:0] r4;
  state_t      st4;

  logic_serial_issuer #(.word_width(16), .lanes(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .req_valid_i(v4), .req_ready_o(ready4),
    .req_op_i(op4), .req_a_i(a4), .req_b_i(b4), .rsp_valid_o(rv4),
    .rsp_ready_i(rr4), .rsp_r_o(r4), .rsp_zero_o(z4), .busy_o(busy4),
    .dbg_state_o(st4)
  );

  // ---------------- DUT with 1 lane ----------------
  logic        rst1 = 1'b1, v1 = 1'b0, rr1 = 1'b1;
  logic [1:0]  op1 = '0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        ready1, rv1, z1, busy1;
  logic [15:0] r1;
  state_t      st1;

  logic_serial_issuer #(.word_width(16), .lanes(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_valid_i(v1), .req_ready_o(ready1),
    .req_op_i(op1), .req_a_i(a1), .req_b_i(b1), .rsp_valid_o(rv1),
    .rsp_ready_i(rr1), .rsp_r_o(r1), .rsp_zero_o(z1), .busy_o(busy1),
    .dbg_state_o(st1)
  );

  // ---------------- scoreboard queues ----------------
  // entry = {zero, result}; acc queue holds the cycle of the accepting handshake
  logic [64:0] exp4_q[$];
  int          acc4_q[$];
  logic [16:0] exp1_q[$];
  int          acc1_q[$];

  // ---------------- monitors ----------------
  logic prev_rv4 = 1'b0;
  always @(negedge clk) begin
    if (rst4) begin
      prev_rv4 = 1'b0;
    end else begin
      if (rv4 && !prev_rv4) begin
        if (acc4_q.size() == 0) fail_now("rsp4_unexpected_valid");
        else check("lat4", 128'(cyc - acc4_q.pop_front()), 128'(5));
      end
      if (rv4 && rr4) begin
        if (exp4_q.size() == 0) fail_now("rsp4_no_expected");
        else check("rsp4", {z4, r4}, exp4_q.pop_front());
      end
      prev_rv4 = rv4;
    end
  end

  logic prev_rv1 = 1'b0;
  always @(negedge clk) begin
    if (rst1) begin
      prev_rv1 = 1'b0;
    end else begin
      if (rv1 && !prev_rv1) begin
        if (acc1_q.size() == 0) fail_now("rsp1_unexpected_valid");
        else check("lat1", 128'(cyc - acc1_q.pop_front()), 128'(2));
      end
      if (rv1 && rr1) begin
        if (exp1_q.size() == 0) fail_now("rsp1_no_expected");
        else check("rsp1", {z1, r1}, exp1_q.pop_front());
      end
      prev_rv1 = rv1;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send4(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_r);
    bit ok = 0;
    v4 = 1'b1; op4 = op; a4 = a; b4 = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready4) begin
        ok = 1;
        exp4_q.push_back({(exp_r == 64'd0), exp_r});
        acc4_q.push_back(cyc);
      end
    end
    if (!ok) fail_now("send4_timeout");
    @(posedge clk); #1;
    // Scramble the payload: the DUT must ignore it after acceptance.
    v4 = 1'b0; a4 = ~a; b4 = {$urandom, $urandom}; op4 = op + 2'd1;
  endtask

  task automatic send1(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_r);
    bit ok = 0;
    v1 = 1'b1; op1 = op; a1 = a; b1 = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready1) begin
        ok = 1;
        exp1_q.push_back({(exp_r == 16'd0), exp_r});
        acc1_q.push_back(cyc);
      end
    end
    if (!ok) fail_now("send1_timeout");
    @(posedge clk); #1;
    v1 = 1'b0; a1 = ~a; b1 = 16'($urandom); op1 = op + 2'd1;
  endtask

  task automatic drain4();
    for (int i = 0; i < 100 && exp4_q.size() != 0; i++) @(posedge clk);
    if (exp4_q.size() != 0) fail_now("drain4_timeout");
    @(posedge clk); #1;
  endtask

  task automatic drain1();
    for (int i = 0; i < 100 && exp1_q.size() != 0; i++) @(posedge clk);
    if (exp1_q.size() != 0) fail_now("drain1_timeout");
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'd0:    return ~b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    bit          seen;

    repeat (3) @(posedge clk);
    #1;
    // reset values while still in reset
    check("rst_ready4", ready4, 1);
    check("rst_rv4",    rv4,    0);
    check("rst_r4",     r4,     0);
    check("rst_z4",     z4,     0);
    check("rst_busy4",  busy4,  0);
    check("rst_state4", st4,    IDLE);
    rst4 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // 1: AND
    send4(2'd1, 64'hFFFF_0F0F_00FF_1234, 64'h0F0F_FFFF_FFFF_00FF, 64'h0F0F_0F0F_00FF_0034);
    check("busy4_run", busy4, 1);
    check("ready4_run", ready4, 0);
    drain4();

    // 2: XOR of equal operands
    send4(2'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h0);
    drain4();

    // 3: NOT B
    send4(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain4();
    send4(2'd0, 64'h1357_9BDF_2468_ACE0, 64'h00FF_0000_FFFF_1234, 64'hFF00_FFFF_0000_EDCB);
    drain4();

    // 4: back-pressure in DONE, then back-to-back accept
    rr4 = 1'b0;
    send4(2'd2, 64'hF000_0F00_00F0_000F, 64'h0F00_00F0_000F_F000, 64'hFF00_0FF0_00FF_F00F);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rv4;
    end
    if (!seen) fail_now("wait_done4_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_r4",     r4,     64'hFF00_0FF0_00FF_F00F);
      check("hold_ready4", ready4, 0);
      check("hold_rv4",    rv4,    1);
    end
    @(posedge clk); #1;
    rr4 = 1'b1;
    send4(2'd1, 64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00, 64'h1200_5600_9A00_DE00);
    check("b2b_busy4",  busy4, 1);
    check("b2b_state4", st4,   RUN);
    drain4();

    // 5: reset in the 2nd RUN cycle discards the request
    send4(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst4 = 1'b1;
    exp4_q.delete();
    acc4_q.delete();
    @(posedge clk); #1;
    rst4 = 1'b0;
    check("rstmid_ready4", ready4, 1);
    check("rstmid_busy4",  busy4,  0);
    check("rstmid_rv4",    rv4,    0);
    check("rstmid_state4", st4,    IDLE);
    repeat (8) @(posedge clk);
    #1;
    send4(2'd2, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003);
    drain4();

    // 6: single lane
    check("idle_ready1", ready1, 1);
    send1(2'd2, 16'h00F0, 16'h0F00, 16'h0FF0);
    drain1();
    for (int n = 0; n < 100; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = (n % 10 == 0) ? ra : 16'($urandom);
      send1(rop, ra, rb, ref_op(rop, ra, rb));
    end
    drain1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
